// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN nibble-serial weight-load path.
package bnn_pkg;

  localparam int NUM_NEURONS = 8;
  localparam int NIBBLE_W    = 4;
  localparam int WORD_W      = 2 * NIBBLE_W;

  typedef logic [WORD_W-1:0] weight_t;

  // GAP is only reachable when the inter-word gap build option is enabled.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    GAP  = 2'd3
  } strm_state_e;

endpackage

// File: rtl/bnn_sync_fifo.sv
// Small synchronous FIFO: registered pointers and count, combinational head read.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module bnn_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  // Push is refused while full even if a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bnn_weight_streamer.sv
// Host-side transmitter for the BNN nibble-serial weight-load bus.
// Buffers 8-bit words and sends each as two nibbles (low first) with
// load_en_out high for exactly those two cycles; tracks the target neuron.
// Build option BNN_STREAM_GAP_EN: insert one idle cycle after every word.
module bnn_weight_streamer
  import bnn_pkg::*;
#(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int IDX_W       = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [NIBBLE_W-1:0] nib_out,
  output logic                load_en_out,
  output logic [IDX_W-1:0]    neuron_idx,
  output logic                busy,
  output logic                frame_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  weight_t             fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                push, pop;

  strm_state_e         state_q;
  logic [NIBBLE_W-1:0] hold_hi_q;
  logic [NIBBLE_W-1:0] nib_q;
  logic                le_q;
  logic [IDX_W-1:0]    idx_q;
  logic                fd_q;

  assign s_ready = !fifo_full;
  assign push    = s_valid && !fifo_full;

  // A word is taken from the FIFO whenever the bus is free for a new low nibble.
`ifdef BNN_STREAM_GAP_EN
  assign pop = !fifo_empty && ((state_q == IDLE) || (state_q == GAP));
`else
  assign pop = !fifo_empty && ((state_q == IDLE) || (state_q == HI));
`endif

  bnn_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (s_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Nibble sequencer with registered bus outputs and neuron/frame tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_hi_q <= '0;
      nib_q     <= '0;
      le_q      <= 1'b0;
      idx_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      case (state_q)
        LO: begin
          nib_q   <= hold_hi_q;
          le_q    <= 1'b1;
          state_q <= HI;
        end
        HI: begin
          if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
            idx_q <= '0;
            fd_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
`ifdef BNN_STREAM_GAP_EN
          nib_q   <= '0;
          le_q    <= 1'b0;
          state_q <= GAP;
`else
          if (pop) begin
            hold_hi_q <= fifo_rdata[WORD_W-1:NIBBLE_W];
            nib_q     <= fifo_rdata[NIBBLE_W-1:0];
            le_q      <= 1'b1;
            state_q   <= LO;
          end else begin
            nib_q   <= '0;
            le_q    <= 1'b0;
            state_q <= IDLE;
          end
`endif
        end
        default: begin
          // IDLE (and GAP when enabled): start a word if one is buffered.
          if (pop) begin
            hold_hi_q <= fifo_rdata[WORD_W-1:NIBBLE_W];
            nib_q     <= fifo_rdata[NIBBLE_W-1:0];
            le_q      <= 1'b1;
            state_q   <= LO;
          end else begin
            nib_q   <= '0;
            le_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign nib_out     = nib_q;
  assign load_en_out = le_q;
  assign neuron_idx  = idx_q;
  assign frame_done  = fd_q;
  assign busy        = (fifo_cnt != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Randomised bench for bnn_weight_streamer with a transaction-level model:
// a queue of accepted words, an occupancy count and a word/frame counter.
module tb_bnn_weight_streamer;

  localparam int N     = 8;
  localparam int IW    = 3;
  localparam int DEPTH = 4;
`ifdef BNN_STREAM_GAP_EN
  localparam bit GAP_MODE = 1'b1;
`else
  localparam bit GAP_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [3:0]    nib_out;
  logic          load_en_out;
  logic [IW-1:0] neuron_idx;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  bnn_weight_streamer #(.NUM_NEURONS(N), .IDX_W(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .nib_out     (nib_out),
    .load_en_out (load_en_out),
    .neuron_idx  (neuron_idx),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (sampled on falling edge) ----------------
  // kind: 0 bus idle, 1 low nibble, 2 high nibble, 3 gap cycle
  logic [7:0] exp_q[$];
  int pushed = 0, started = 0, done = 0;
  int prev_kind = 0, prev_occ = 0;
  int m_kind, m_occ;
  int run_len = 0, last_run = 0, fd_total = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pushed = 0; started = 0; done = 0;
      prev_kind = 0; prev_occ = 0; run_len = 0;
    end else begin
      case (prev_kind)
        1:       m_kind = 2;
        2:       m_kind = GAP_MODE ? 3 : ((prev_occ > 0) ? 1 : 0);
        default: m_kind = (prev_occ > 0) ? 1 : 0;
      endcase
      chk("load_en", load_en_out, (m_kind == 1) || (m_kind == 2));
      chk("neuron_idx", neuron_idx, done % N);
      chk("frame_done", frame_done, (prev_kind == 2) && (done % N == 0));
      if (m_kind == 1 || m_kind == 2) begin
        chk("word_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          if (m_kind == 1) begin
            chk("nib_lo", nib_out, exp_q[0][3:0]);
            started++;
          end else begin
            chk("nib_hi", nib_out, exp_q[0][7:4]);
            void'(exp_q.pop_front());
            done++;
          end
        end
      end else begin
        chk("nib_idle", nib_out, 0);
      end
      m_occ = pushed - started;
      chk("s_ready", s_ready, m_occ < DEPTH);
      chk("busy", busy, (m_occ != 0) || (m_kind != 0));
      if (load_en_out) run_len++;
      else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
      if (frame_done) fd_total++;
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        pushed++;
      end
      prev_kind = m_kind;
      prev_occ  = m_occ;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one word, holding it until accepted; returns whether it stalled.
  task automatic push_one(input logic [7:0] d, output bit stalled);
    int  guard;
    bit  acc;
    guard = 0;
    s_data = d; s_valid = 1'b1;
    do begin
      acc = s_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 50);
    stalled = (guard > 1);
    if (!acc) chk("push_timeout", guard, 0);
  endtask

  bit         st, any_stall;
  int         fd0;
  logic [5:0] pat;
  bit         acc_r;

  initial begin
    // reset values
    @(negedge clk); #1;
    chk("rst_nib", nib_out, 0);
    chk("rst_le", load_en_out, 0);
    chk("rst_idx", neuron_idx, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 1);
    @(negedge clk); #2 rst_n = 1'b1;
    tick(2);

    // single word latency
    push_one(8'hA5, st);
    s_valid = 1'b0;
    tick(1);
    chk("t1_lo_nib", nib_out, 4'h5);
    chk("t1_lo_le", load_en_out, 1);
    tick(1);
    chk("t1_hi_nib", nib_out, 4'hA);
    chk("t1_hi_le", load_en_out, 1);
    tick(1);
    chk("t1_end_le", load_en_out, 0);
    chk("t1_idx", neuron_idx, 1);

    // back-to-back full frame
    tick(3);
    fd0 = fd_total;
    for (int i = 0; i < 8; i++) push_one(8'h10 + 8'(i), st);
    s_valid = 1'b0;
    tick(30);
    chk("t2_run_len", last_run, GAP_MODE ? 2 : 16);
    chk("t2_frame_done_cnt", fd_total - fd0, 1);

    // held valid while busy: must back-pressure, order kept by the model
    any_stall = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_one(8'($urandom), st);
      any_stall |= st;
    end
    s_valid = 1'b0;
    chk("t3_stalled", any_stall, 1);
    tick(40);
    chk("t3_drained", busy, 0);

    // asynchronous reset during HI
    push_one(8'h3C, st);
    s_valid = 1'b0;
    tick(2);
    chk("t4_in_hi", nib_out, 4'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_le", load_en_out, 0);
    chk("t4_nib", nib_out, 0);
    chk("t4_idx", neuron_idx, 0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", s_ready, 1);
    @(negedge clk); #2 rst_n = 1'b1;
    tick(3);

    // two-word strobe pattern
    push_one(8'h21, st);
    push_one(8'h43, st);
    s_valid = 1'b0;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      pat = {pat[4:0], load_en_out};
      tick(1);
    end
    chk("t5_pattern", pat, GAP_MODE ? 6'b110110 : 6'b111100);
    tick(5);

    // random traffic; data held stable while stalled
    s_valid = 1'b0;
    for (int c = 0; c < 500; c++) begin
      acc_r = s_valid && s_ready;
      if (acc_r || !s_valid) begin
        s_valid = ($urandom_range(0, 9) < 6);
        s_data  = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    tick(40);
    chk("rand_all_sent", exp_q.size(), 0);
    chk("rand_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
